pwm_counter_sequencer: RTL and testbench
========================================

Name: pwm_counter_sequencer

Overview:
Controller that owns the run, sync and limit inputs of N_CHANNELS PWM timebase counters.
- Starts the counters in a staggered sequence, giving phase-shifted carriers.
- Holds per-channel start/stop limits in shadow registers and commits them only at each counter's reload point, so a running carrier never sees a torn period.
- Sits between the register-file/AXI slave and the counter bank of the PWM generator.

Parameters:
COUNTER_WIDTH, 16, width of counter start/stop limits
N_CHANNELS, 3, number of counters sequenced (>=1)
DELAY_WIDTH, 16, width of stagger delay counter (timebase ticks)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
timebase  in  1  counter tick enable, shared with counter bank
start_request  in  1  single-cycle pulse: begin staggered start
stop_request  in  1  single-cycle pulse: stop all counters
mode_in  in  2  counter mode (0 down, 1 up, 2 up-down), latched at start
stagger_delay  in  DELAY_WIDTH  timebase ticks between successive channel starts, latched at start
sync_in  in  1  external resync request
cfg_valid  in  1  limit write strobe
cfg_ready  out  1  write accepted this cycle when high with cfg_valid
cfg_channel  in  $clog2(N_CHANNELS) (min 1)  target channel
cfg_start  in  COUNTER_WIDTH  new start limit
cfg_stop  in  COUNTER_WIDTH  new stop limit
reload_in  in  N_CHANNELS  per-channel reload flag from counters
run_out  out  N_CHANNELS  per-channel counter run
sync_out  out  N_CHANNELS  per-channel counter sync (active high)
mode_out  out  2  latched mode to counters
counter_start_data  out  N_CHANNELS*COUNTER_WIDTH  active start limits, channel 0 in LSBs
counter_stop_data  out  N_CHANNELS*COUNTER_WIDTH  active stop limits, channel 0 in LSBs
pending  out  N_CHANNELS  shadow write awaiting commit
state_out  out  2  FSM state

Behaviour:
- Reset (async, reset=0) forces all outputs, active limits, shadows and pending to 0, mode_out=0 and state IDLE. Asynchronous mid-operation reset behaves identically.
- FSM encoding: IDLE=0, STAGGER=1, RUNNING=2, STOPPING=3. All outputs are registered.
- IDLE:
  - run_out=0.
  - Writes with cfg_valid go straight to the active limits 1 cycle later; cfg_ready=1.
  - start_request latches mode_in into mode_out, latches stagger_delay, clears index k and delay count, then goes to STAGGER.
- STAGGER:
  - run_out[0] rises on the first STAGGER cycle.
  - After each further stagger_delay timebase ticks, run_out[k+1] rises.
  - When run_out[N-1] rises, go to RUNNING on the same edge.
  - stagger_delay=0: all run_out bits rise on consecutive clocks, one per clock.
  - N_CHANNELS=1: go directly to RUNNING after run_out[0].
- Limit writes in STAGGER and RUNNING:
  - The write loads shadow[cfg_channel] and sets pending[cfg_channel].
  - cfg_ready = ~pending[cfg_channel]. A write to a pending channel stalls until its commit.
  - Commit happens when reload_in[c] & timebase & pending[c]: the active limits take the shadow values and pending[c] clears on the same edge.
  - A channel not yet started in STAGGER commits immediately on the next clock.
- RUNNING:
  - run_out is all ones.
  - sync_in=1 produces sync_out = all ones for exactly 1 clock, on the clock after sync_in is sampled.
  - sync_in is ignored in IDLE, STAGGER and STOPPING.
- stop_request in STAGGER or RUNNING:
  - run_out clears on the next edge and the FSM enters STOPPING.
  - In STOPPING all pending shadows commit, pending clears, then the FSM returns to IDLE on the next clock. STOPPING lasts exactly 1 cycle.
- Simultaneous events:
  - start_request with stop_request: stop wins; from IDLE, the start is dropped.
  - start_request outside IDLE is ignored.
  - cfg write and commit on the same channel in the same cycle: the commit uses the old shadow; the new write is not accepted (cfg_ready=0).
- Width rules:
  - Limits are stored unsigned and unmodified; no arithmetic is applied.
  - The stagger counter saturates, never wraps.
  - cfg_channel >= N_CHANNELS: the write is discarded with cfg_ready=1.

Test Plan:
- Reset during RUNNING with run_out=3'b111 and pending=3'b010 -> all outputs 0 immediately, state_out=0.
- N=3, stagger_delay=4, timebase every 2 clocks, start_request -> run_out goes 001, then 011 after 4 ticks (8 clocks), then 111 after 4 more ticks; state_out=2.
- RUNNING, write ch1 start=10 stop=500 -> pending=010; no change until reload_in[1]&timebase; then stop_data[ch1]=500 and pending=000 on that edge. A second write to ch1 while pending -> cfg_ready=0.
- IDLE write ch2 stop=1000 -> counter_stop_data[ch2]=1000 after 1 clock, pending stays 0.
- RUNNING with pending=001, stop_request -> next clock run_out=000 and state=3; following clock active ch0 limits updated, pending=0, state=0.
- start_request and stop_request together in IDLE -> state remains 0. sync_in pulse in RUNNING -> sync_out=111 for one clock, one clock later.

Source files
------------

// File: rtl/pwm_counter_sequencer.sv
// Sequencer for a bank of PWM timebase counters: staggered start, sync fan-out and
// shadowed start/stop limits that commit only at each counter's reload point.
module pwm_counter_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned N_CHANNELS    = 3,
    parameter int unsigned DELAY_WIDTH   = 16,
    localparam int unsigned CH_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                timebase,
    input  logic                                start_request,
    input  logic                                stop_request,
    input  logic [1:0]                          mode_in,
    input  logic [DELAY_WIDTH-1:0]              stagger_delay,
    input  logic                                sync_in,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [CH_W-1:0]                     cfg_channel,
    input  logic [COUNTER_WIDTH-1:0]            cfg_start,
    input  logic [COUNTER_WIDTH-1:0]            cfg_stop,
    input  logic [N_CHANNELS-1:0]               reload_in,
    output logic [N_CHANNELS-1:0]               run_out,
    output logic [N_CHANNELS-1:0]               sync_out,
    output logic [1:0]                          mode_out,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] counter_start_data,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] counter_stop_data,
    output logic [N_CHANNELS-1:0]               pending,
    output logic [1:0]                          state_out
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStagger  = 2'd1,
        StRunning  = 2'd2,
        StStopping = 2'd3
    } state_e;

    state_e                                     state_q;
    logic [N_CHANNELS-1:0]                      run_q;
    logic [N_CHANNELS-1:0]                      sync_q;
    logic [1:0]                                 mode_q;
    logic [DELAY_WIDTH-1:0]                     delay_q;
    logic [DELAY_WIDTH-1:0]                     cnt_q;
    logic [CH_W-1:0]                            idx_q;
    logic [N_CHANNELS-1:0]                      pending_q;
    logic [N_CHANNELS-1:0][COUNTER_WIDTH-1:0]   start_act_q;
    logic [N_CHANNELS-1:0][COUNTER_WIDTH-1:0]   stop_act_q;
    logic [N_CHANNELS-1:0][COUNTER_WIDTH-1:0]   start_shd_q;
    logic [N_CHANNELS-1:0][COUNTER_WIDTH-1:0]   stop_shd_q;

    logic                  ch_valid;
    logic                  wr;
    logic [N_CHANNELS-1:0] commit;
    logic [CH_W-1:0]       idx_next;
    logic                  stag_fire;

    assign idx_next  = idx_q + 1'b1;
    // A zero delay releases one channel per clock, independent of the timebase.
    assign stag_fire = (delay_q == '0) || (timebase && (cnt_q >= delay_q - 1'b1));

    always_comb begin
        ch_valid  = 32'(cfg_channel) < N_CHANNELS;
        cfg_ready = 1'b1;
        commit    = '0;
        case (state_q)
            StIdle:    cfg_ready = 1'b1;
            StStagger,
            StRunning: cfg_ready = ch_valid ? ~pending_q[cfg_channel] : 1'b1;
            default:   cfg_ready = 1'b0;
        endcase
        wr = cfg_valid && cfg_ready && ch_valid;
        for (int c = 0; c < int'(N_CHANNELS); c++) begin
            if (state_q == StStopping) begin
                commit[c] = pending_q[c];
            end else if (state_q == StStagger || state_q == StRunning) begin
                // Channels still waiting for their stagger slot have no carrier to tear.
                commit[c] = pending_q[c] &&
                            ((reload_in[c] && timebase) || (state_q == StStagger && !run_q[c]));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            run_q       <= '0;
            sync_q      <= '0;
            mode_q      <= '0;
            delay_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= '0;
            start_act_q <= '0;
            stop_act_q  <= '0;
            start_shd_q <= '0;
            stop_shd_q  <= '0;
        end else begin
            sync_q <= '0;
            for (int c = 0; c < int'(N_CHANNELS); c++) begin
                if (commit[c]) begin
                    start_act_q[c] <= start_shd_q[c];
                    stop_act_q[c]  <= stop_shd_q[c];
                    pending_q[c]   <= 1'b0;
                end
            end
            case (state_q)
                StIdle: begin
                    run_q <= '0;
                    if (wr) begin
                        start_act_q[cfg_channel] <= cfg_start;
                        stop_act_q[cfg_channel]  <= cfg_stop;
                    end
                    if (start_request && !stop_request) begin
                        mode_q   <= mode_in;
                        delay_q  <= stagger_delay;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        run_q[0] <= 1'b1;
                        state_q  <= (N_CHANNELS == 1) ? StRunning : StStagger;
                    end
                end
                StStagger, StRunning: begin
                    if (wr) begin
                        start_shd_q[cfg_channel] <= cfg_start;
                        stop_shd_q[cfg_channel]  <= cfg_stop;
                        pending_q[cfg_channel]   <= 1'b1;
                    end
                    if (stop_request) begin
                        run_q   <= '0;
                        state_q <= StStopping;
                    end else if (state_q == StRunning) begin
                        sync_q <= {N_CHANNELS{sync_in}};
                    end else if (stag_fire) begin
                        cnt_q           <= '0;
                        idx_q           <= idx_next;
                        run_q[idx_next] <= 1'b1;
                        if (32'(idx_next) == N_CHANNELS - 1) begin
                            state_q <= StRunning;
                        end
                    end else if (timebase && cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    run_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign run_out            = run_q;
    assign sync_out           = sync_q;
    assign mode_out           = mode_q;
    assign counter_start_data = start_act_q;
    assign counter_stop_data  = stop_act_q;
    assign pending            = pending_q;
    assign state_out          = state_q;

endmodule

// File: tb/tb_pwm_counter_sequencer.sv
// Scenario bench for pwm_counter_sequencer: expected limits and run patterns are queued
// when stimulus is driven and popped when the sequencer produces them.
module tb_pwm_counter_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        timebase;
    logic        start_request;
    logic        stop_request;
    logic [1:0]  mode_in;
    logic [15:0] stagger_delay;
    logic        sync_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_channel;
    logic [15:0] cfg_start;
    logic [15:0] cfg_stop;
    logic [2:0]  reload_in;
    logic [2:0]  run_out;
    logic [2:0]  sync_out;
    logic [1:0]  mode_out;
    logic [47:0] counter_start_data;
    logic [47:0] counter_stop_data;
    logic [2:0]  pending;
    logic [1:0]  state_out;

    pwm_counter_sequencer #(
        .COUNTER_WIDTH(16),
        .N_CHANNELS   (3),
        .DELAY_WIDTH  (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .timebase          (timebase),
        .start_request     (start_request),
        .stop_request      (stop_request),
        .mode_in           (mode_in),
        .stagger_delay     (stagger_delay),
        .sync_in           (sync_in),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_channel       (cfg_channel),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .reload_in         (reload_in),
        .run_out           (run_out),
        .sync_out          (sync_out),
        .mode_out          (mode_out),
        .counter_start_data(counter_start_data),
        .counter_stop_data (counter_stop_data),
        .pending           (pending),
        .state_out         (state_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          ch;
        logic [15:0] st;
        logic [15:0] sp;
    } lim_t;

    lim_t        exp_q[$];
    logic [2:0]  run_exp[$];
    logic [1:0]  state_exp[$];
    logic [15:0] m_start[3];
    logic [15:0] m_stop[3];
    int          total = 0;
    int          bad = 0;
    int          ticks_seen = 0;
    bit          tb_alt = 0;

    function automatic logic [47:0] pack_model(input bit stop_side);
        logic [47:0] v;
        for (int c = 0; c < 3; c++) v[c*16 +: 16] = stop_side ? m_stop[c] : m_start[c];
        return v;
    endfunction

    task automatic step();
        logic tb_prev;
        tb_prev = timebase;
        @(posedge clock);
        #1;
        if (tb_prev) ticks_seen++;
        if (tb_alt) timebase = ~timebase;
    endtask

    task automatic apply_commit();
        lim_t e;
        e = exp_q.pop_front();
        m_start[e.ch] = e.st;
        m_stop[e.ch]  = e.sp;
    endtask

    task automatic go_running();
        mode_in = 2'd1; stagger_delay = 16'd0;
        start_request = 1'b1;
        step();
        start_request = 1'b0;
        for (int i = 0; i < 10 && state_out !== 2'd2; i++) step();
        total++;
        if (state_out !== 2'd2 || run_out !== 3'b111) begin
            bad++;
            $display("FAIL go_running: state=%0d run=%b, need state=2 run=111", state_out, run_out);
        end
    endtask

    task automatic do_stop();
        stop_request = 1'b1;
        step();
        stop_request = 1'b0;
        step();
        total++;
        if (state_out !== 2'd0) begin
            bad++;
            $display("FAIL do_stop: state=%0d, need 0", state_out);
        end
    endtask

    task automatic test_reset();
        step(); step();
        total++;
        if ({run_out, sync_out, mode_out, pending, state_out} !== 13'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %h, need 0", {run_out, sync_out, mode_out, pending, state_out});
        end
        total++;
        if (counter_start_data !== 48'd0 || counter_stop_data !== 48'd0) begin
            bad++;
            $display("FAIL reset_limits: start=%h stop=%h, need 0", counter_start_data, counter_stop_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_idle_write();
        cfg_valid = 1'b1; cfg_channel = 2'd2; cfg_start = 16'd7; cfg_stop = 16'd1000;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL idle_ready: got %b, need 1", cfg_ready);
        end
        exp_q.push_back('{2, 16'd7, 16'd1000});
        step();
        cfg_valid = 1'b0;
        apply_commit();
        total++;
        if (counter_stop_data !== pack_model(1) || counter_start_data !== pack_model(0)) begin
            bad++;
            $display("FAIL idle_write: stop=%h start=%h, need stop=%h start=%h", counter_stop_data,
                     counter_start_data, pack_model(1), pack_model(0));
        end
        total++;
        if (pending !== 3'b000) begin
            bad++; $display("FAIL idle_pending: got %b, need 000", pending);
        end
        // Out-of-range channel is accepted and thrown away.
        cfg_valid = 1'b1; cfg_channel = 2'd3; cfg_start = 16'd99; cfg_stop = 16'd99;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL oob_ready: got %b, need 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        total++;
        if (counter_stop_data !== pack_model(1) || counter_start_data !== pack_model(0)) begin
            bad++;
            $display("FAIL oob_discard: stop=%h start=%h, need stop=%h start=%h", counter_stop_data,
                     counter_start_data, pack_model(1), pack_model(0));
        end
    endtask

    task automatic test_stagger();
        logic [2:0] last_run;
        logic [2:0] er;
        logic [1:0] es;
        run_exp.push_back(3'b001); state_exp.push_back(2'd1);
        run_exp.push_back(3'b011); state_exp.push_back(2'd1);
        run_exp.push_back(3'b111); state_exp.push_back(2'd2);
        mode_in = 2'd2; stagger_delay = 16'd4; timebase = 1'b0; tb_alt = 1;
        start_request = 1'b1;
        step();
        start_request = 1'b0;
        ticks_seen = 0;
        er = run_exp.pop_front(); es = state_exp.pop_front();
        total++;
        if (run_out !== er || state_out !== es || mode_out !== 2'd2) begin
            bad++;
            $display("FAIL stagger_first: run=%b state=%0d mode=%0d, need run=%b state=%0d mode=2",
                     run_out, state_out, mode_out, er, es);
        end
        last_run = run_out;
        for (int i = 0; i < 100 && run_exp.size() > 0; i++) begin
            step();
            if (run_out !== last_run) begin
                er = run_exp.pop_front(); es = state_exp.pop_front();
                total++;
                if (run_out !== er || state_out !== es || ticks_seen != 4) begin
                    bad++;
                    $display("FAIL stagger_step: run=%b state=%0d ticks=%0d, need run=%b state=%0d ticks=4",
                             run_out, state_out, ticks_seen, er, es);
                end
                ticks_seen = 0;
                last_run = run_out;
            end
        end
        total++;
        if (run_exp.size() != 0) begin
            bad++;
            $display("FAIL stagger_timeout: %0d steps left, need 0", run_exp.size());
            run_exp.delete(); state_exp.delete();
        end
        tb_alt = 0; timebase = 1'b0;
        do_stop();
    endtask

    task automatic test_commit();
        go_running();
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_start = 16'd10; cfg_stop = 16'd500;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL run_ready: got %b, need 1", cfg_ready);
        end
        exp_q.push_back('{1, 16'd10, 16'd500});
        step();
        cfg_valid = 1'b0;
        timebase = 1'b1;
        step(); step();
        // reload without a timebase tick must not commit either
        timebase = 1'b0; reload_in = 3'b010;
        step();
        total++;
        if (pending !== 3'b010 || counter_stop_data !== pack_model(1)) begin
            bad++;
            $display("FAIL shadow_hold: pending=%b stop=%h, need pending=010 stop=%h", pending,
                     counter_stop_data, pack_model(1));
        end
        cfg_valid = 1'b1; cfg_start = 16'd11; cfg_stop = 16'd600;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++; $display("FAIL pending_stall: ready=%b, need 0", cfg_ready);
        end
        timebase = 1'b1;
        step();
        apply_commit();
        total++;
        if (counter_stop_data !== pack_model(1) || counter_start_data !== pack_model(0) ||
            pending !== 3'b000) begin
            bad++;
            $display("FAIL commit: stop=%h start=%h pending=%b, need stop=%h start=%h pending=000",
                     counter_stop_data, counter_start_data, pending, pack_model(1), pack_model(0));
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_commit: got %b, need 1", cfg_ready);
        end
        cfg_valid = 1'b0; reload_in = 3'b000; timebase = 1'b0;
        do_stop();
    endtask

    task automatic test_stop();
        go_running();
        cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_start = 16'd20; cfg_stop = 16'd30;
        exp_q.push_back('{0, 16'd20, 16'd30});
        step();
        cfg_valid = 1'b0;
        total++;
        if (pending !== 3'b001) begin
            bad++; $display("FAIL stop_pending: got %b, need 001", pending);
        end
        stop_request = 1'b1;
        step();
        stop_request = 1'b0;
        total++;
        if (run_out !== 3'b000 || state_out !== 2'd3 || counter_start_data !== pack_model(0)) begin
            bad++;
            $display("FAIL stopping: run=%b state=%0d start=%h, need run=000 state=3 start=%h",
                     run_out, state_out, counter_start_data, pack_model(0));
        end
        step();
        apply_commit();
        total++;
        if (counter_start_data !== pack_model(0) || counter_stop_data !== pack_model(1) ||
            pending !== 3'b000 || state_out !== 2'd0) begin
            bad++;
            $display("FAIL stop_flush: start=%h stop=%h pending=%b state=%0d, need %h %h 000 0",
                     counter_start_data, counter_stop_data, pending, state_out, pack_model(0),
                     pack_model(1));
        end
    endtask

    task automatic test_start_stop_idle();
        start_request = 1'b1; stop_request = 1'b1;
        step();
        start_request = 1'b0; stop_request = 1'b0;
        step(); step();
        total++;
        if (state_out !== 2'd0 || run_out !== 3'b000) begin
            bad++; $display("FAIL start_stop_idle: state=%0d run=%b, need 0 000", state_out, run_out);
        end
    endtask

    task automatic test_sync();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        total++;
        if (sync_out !== 3'b000) begin
            bad++; $display("FAIL sync_idle: got %b, need 000", sync_out);
        end
        go_running();
        sync_in = 1'b1;
        #1;
        total++;
        if (sync_out !== 3'b000) begin
            bad++; $display("FAIL sync_early: got %b, need 000", sync_out);
        end
        step();
        sync_in = 1'b0;
        total++;
        if (sync_out !== 3'b111) begin
            bad++; $display("FAIL sync_pulse: got %b, need 111", sync_out);
        end
        step();
        total++;
        if (sync_out !== 3'b000) begin
            bad++; $display("FAIL sync_width: got %b, need 000", sync_out);
        end
        do_stop();
    endtask

    task automatic test_reset_running();
        go_running();
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_start = 16'd3; cfg_stop = 16'd4;
        step();
        cfg_valid = 1'b0;
        total++;
        if (run_out !== 3'b111 || pending !== 3'b010) begin
            bad++; $display("FAIL pre_reset: run=%b pending=%b, need 111 010", run_out, pending);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({run_out, sync_out, mode_out, pending, state_out} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset_ctrl: got %h, need 0",
                     {run_out, sync_out, mode_out, pending, state_out});
        end
        total++;
        if (counter_start_data !== 48'd0 || counter_stop_data !== 48'd0) begin
            bad++;
            $display("FAIL async_reset_limits: start=%h stop=%h, need 0", counter_start_data,
                     counter_stop_data);
        end
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            m_start[c] = '0; m_stop[c] = '0;
        end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; timebase = 1'b0; start_request = 1'b0; stop_request = 1'b0;
        mode_in = '0; stagger_delay = '0; sync_in = 1'b0; cfg_valid = 1'b0;
        cfg_channel = '0; cfg_start = '0; cfg_stop = '0; reload_in = '0;
        for (int c = 0; c < 3; c++) begin
            m_start[c] = '0; m_stop[c] = '0;
        end
        test_reset();
        test_idle_write();
        test_stagger();
        test_commit();
        test_stop();
        test_start_stop_idle();
        test_sync();
        test_reset_running();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
